// File: rtl/seq_num_decoder_if.sv
// Byte-stream and result bundle between the received message processor,
// the sequence generator, the session manager and seq_num_decoder.
interface seq_num_decoder_if #(
  parameter int SEQ_W = 32
);
  logic             byte_valid_i;
  logic [7:0]       byte_i;
  logic             field_start_i;
  logic             field_end_i;
  logic [SEQ_W-1:0] expected_seq_num_i;
  logic             ready_o;
  logic             done_o;
  logic [SEQ_W-1:0] seq_num_o;
  logic [3:0]       width_o;
  logic             in_sequence_o;
  logic             gap_o;
  logic             too_low_o;
  logic             error_o;
  logic [SEQ_W-1:0] gap_size_o;

  // Upstream side: supplies bytes, strobes and the expected number.
  modport master (
    output byte_valid_i, byte_i, field_start_i, field_end_i, expected_seq_num_i,
    input  ready_o, done_o, seq_num_o, width_o, in_sequence_o, gap_o,
           too_low_o, error_o, gap_size_o
  );

  // Decoder side.
  modport slave (
    input  byte_valid_i, byte_i, field_start_i, field_end_i, expected_seq_num_i,
    output ready_o, done_o, seq_num_o, width_o, in_sequence_o, gap_o,
           too_low_o, error_o, gap_size_o
  );
endinterface

// File: rtl/seq_num_decoder.sv
// FIX MsgSeqNum (tag 34) receive decoder: ASCII digits -> binary, then
// classified against the expected sequence number.
// Optional feature macro: SEQ_DECODER_GAP_SIZE_EN (builds the gap-size subtractor).
//
// state | meaning
// IDLE  | waiting for a field_start byte
// ACCUM | accumulating digits until field_end
// CHECK | comparing accumulator with expected number, results registered
// DONE  | one-cycle done strobe
module seq_num_decoder #(
  parameter int MAX_DIGITS = 10,
  parameter int SEQ_W      = 32
) (
  input logic           clk,
  input logic           rst,
  seq_num_decoder_if.slave bus
);
  localparam int AW = SEQ_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             err_q, err_d;
  logic [SEQ_W-1:0] seq_num_q, seq_num_d;
  logic [3:0]       width_q, width_d;
  logic             in_seq_q, in_seq_d;
  logic             gap_q, gap_d;
  logic             too_low_q, too_low_d;
  logic             error_q, error_d;

  logic             accepting, start_evt, take_byte, end_evt, is_digit;
  logic [SEQ_W-1:0] base_acc;
  logic [3:0]       base_cnt, cnt_inc;
  logic             base_err;
  logic [AW-1:0]    acc_ext, acc_x10;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a single-byte field may start and end in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.byte_valid_i && bus.field_start_i)
                 state_d = bus.field_end_i ? S_CHECK : S_ACCUM;
      S_ACCUM: if (bus.field_end_i) state_d = S_CHECK;
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.ready_o = (state_q == S_IDLE) || (state_q == S_ACCUM);
    bus.done_o  = (state_q == S_DONE);
  end

  // Digit accumulation; a field_start byte discards any field in progress.
  always_comb begin
    accepting = (state_q == S_IDLE) || (state_q == S_ACCUM);
    start_evt = accepting && bus.byte_valid_i && bus.field_start_i;
    take_byte = bus.byte_valid_i && (start_evt || (state_q == S_ACCUM));
    end_evt   = bus.field_end_i && (start_evt || (state_q == S_ACCUM));
    is_digit  = (bus.byte_i >= 8'h30) && (bus.byte_i <= 8'h39);
    base_acc  = start_evt ? '0   : acc_q;
    base_cnt  = start_evt ? 4'd0 : count_q;
    base_err  = start_evt ? 1'b0 : err_q;
    cnt_inc   = (base_cnt == 4'hF) ? 4'hF : base_cnt + 4'd1;
    acc_ext   = {4'b0000, base_acc};
    // For 0x30..0x39 the low nibble is exactly byte - 0x30.
    acc_x10   = (acc_ext << 3) + (acc_ext << 1) + AW'(bus.byte_i[3:0]);
    acc_d     = acc_q;
    count_d   = count_q;
    err_d     = err_q;
    if (take_byte) begin
      acc_d   = base_acc;
      count_d = base_cnt;
      err_d   = base_err;
      if (!is_digit) begin
        err_d = 1'b1;
      end else begin
        count_d = cnt_inc;
        if (int'(cnt_inc) > MAX_DIGITS) err_d = 1'b1;
        if (acc_x10[AW-1:SEQ_W] != 4'b0000) err_d = 1'b1;
        if (!err_d) acc_d = acc_x10[SEQ_W-1:0];
      end
    end
    if (end_evt && (count_d == 4'd0)) err_d = 1'b1;
  end

  // Result computation; results are captured leaving CHECK and held until the next DONE.
  always_comb begin
    seq_num_d = seq_num_q;
    width_d   = width_q;
    in_seq_d  = in_seq_q;
    gap_d     = gap_q;
    too_low_d = too_low_q;
    error_d   = error_q;
    if (state_q == S_CHECK) begin
      width_d = count_q;
      error_d = err_q;
      if (err_q) begin
        seq_num_d = '0;
        in_seq_d  = 1'b0;
        gap_d     = 1'b0;
        too_low_d = 1'b0;
      end else begin
        seq_num_d = acc_q;
        in_seq_d  = (acc_q == bus.expected_seq_num_i);
        gap_d     = (acc_q >  bus.expected_seq_num_i);
        too_low_d = (acc_q <  bus.expected_seq_num_i);
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      count_q   <= 4'd0;
      err_q     <= 1'b0;
      seq_num_q <= '0;
      width_q   <= 4'd0;
      in_seq_q  <= 1'b0;
      gap_q     <= 1'b0;
      too_low_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      count_q   <= count_d;
      err_q     <= err_d;
      seq_num_q <= seq_num_d;
      width_q   <= width_d;
      in_seq_q  <= in_seq_d;
      gap_q     <= gap_d;
      too_low_q <= too_low_d;
      error_q   <= error_d;
    end
  end

`ifdef SEQ_DECODER_GAP_SIZE_EN
  logic [SEQ_W-1:0] gap_size_q, gap_size_d;

  // Gap size is only meaningful for a clean field that is ahead of expected.
  always_comb begin
    gap_size_d = gap_size_q;
    if (state_q == S_CHECK) begin
      if (!err_q && (acc_q > bus.expected_seq_num_i))
        gap_size_d = acc_q - bus.expected_seq_num_i;
      else
        gap_size_d = '0;
    end
  end

  // Gap size register.
  always_ff @(posedge clk) begin
    if (rst) gap_size_q <= '0;
    else     gap_size_q <= gap_size_d;
  end

  assign bus.gap_size_o = gap_size_q;
`else
  assign bus.gap_size_o = '0;
`endif

  assign bus.seq_num_o     = seq_num_q;
  assign bus.width_o       = width_q;
  assign bus.in_sequence_o = in_seq_q;
  assign bus.gap_o         = gap_q;
  assign bus.too_low_o     = too_low_q;
  assign bus.error_o       = error_q;
endmodule

// File: tb/tb_seq_num_decoder.sv
// Randomized and directed bench for seq_num_decoder against a string-level
// reference model of the MsgSeqNum field rules.
module tb_seq_num_decoder;
  localparam int MAXD = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_num_decoder_if #(.SEQ_W(32)) dut_if ();
  seq_num_decoder #(.MAX_DIGITS(MAXD), .SEQ_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(negedge clk) if (dut_if.done_o === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  byte unsigned fld[$];
  logic [31:0]     m_val, m_gsz;
  logic [3:0]      m_w;
  logic            m_err, m_ins, m_gap, m_low;
  longint unsigned m_raw;

  // Reference: decimal value of the whole string, classified afterwards.
  task automatic model(input logic [31:0] exp_seq);
    longint unsigned v = 0;
    int nd = 0;
    bit bad = 0;
    foreach (fld[i]) begin
      if (fld[i] >= 8'h30 && fld[i] <= 8'h39) begin
        nd++;
        if (v <= 64'hFFFF_FFFF) v = v * 10 + longint'(fld[i] - 8'h30);
      end else begin
        bad = 1;
      end
    end
    m_raw = v;
    m_err = bad || (nd == 0) || (nd > MAXD) || (v > 64'hFFFF_FFFF);
    m_ins = 0; m_gap = 0; m_low = 0; m_gsz = 0; m_val = 0;
    m_w   = (nd > 15) ? 4'd15 : 4'(nd);
    if (!m_err) begin
      m_val = v[31:0];
      m_ins = (v == 64'(exp_seq));
      m_gap = (v >  64'(exp_seq));
      m_low = (v <  64'(exp_seq));
`ifdef SEQ_DECODER_GAP_SIZE_EN
      if (m_gap) m_gsz = v[31:0] - exp_seq;
`endif
    end
  endtask

  task automatic set_fld(input string s);
    fld.delete();
    for (int i = 0; i < s.len(); i++) fld.push_back(s[i]);
  endtask

  task automatic clear_in();
    dut_if.byte_valid_i  = 0;
    dut_if.byte_i        = 8'h00;
    dut_if.field_start_i = 0;
    dut_if.field_end_i   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_field(input logic [31:0] exp_seq, input bit end_with_last, input bit gaps);
    dut_if.expected_seq_num_i = exp_seq;
    foreach (fld[i]) begin
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) tick();
      dut_if.byte_valid_i  = 1;
      dut_if.byte_i        = fld[i];
      dut_if.field_start_i = (i == 0);
      dut_if.field_end_i   = end_with_last && (i == fld.size() - 1);
      tick();
      clear_in();
    end
    if (!end_with_last) begin
      dut_if.field_end_i = 1;
      tick();
      clear_in();
    end
  endtask

  // Entered #1 after the edge that sampled field_end: DUT is in CHECK.
  task automatic finish_field(input string tag);
    int dc0 = done_cnt;
    chk({tag, ".ready_chk"}, 64'(dut_if.ready_o), 0);
    chk({tag, ".done_chk"}, 64'(dut_if.done_o), 0);
    if ($urandom_range(0, 1) == 1) begin
      dut_if.byte_valid_i = 1; dut_if.field_start_i = 1;
      dut_if.field_end_i = 1; dut_if.byte_i = 8'h35;
    end
    tick();
    clear_in();
    dut_if.expected_seq_num_i = $urandom;
    chk({tag, ".done"},    64'(dut_if.done_o), 1);
    chk({tag, ".seq"},     64'(dut_if.seq_num_o), 64'(m_val));
    chk({tag, ".width"},   64'(dut_if.width_o), 64'(m_w));
    chk({tag, ".err"},     64'(dut_if.error_o), 64'(m_err));
    chk({tag, ".in_seq"},  64'(dut_if.in_sequence_o), 64'(m_ins));
    chk({tag, ".gap"},     64'(dut_if.gap_o), 64'(m_gap));
    chk({tag, ".too_low"}, 64'(dut_if.too_low_o), 64'(m_low));
    chk({tag, ".gap_sz"},  64'(dut_if.gap_size_o), 64'(m_gsz));
    if ($urandom_range(0, 1) == 1) begin
      dut_if.byte_valid_i = 1; dut_if.field_start_i = 1;
      dut_if.field_end_i = 1; dut_if.byte_i = 8'h36;
    end
    tick();
    clear_in();
    chk({tag, ".done_off"}, 64'(dut_if.done_o), 0);
    chk({tag, ".ready_on"}, 64'(dut_if.ready_o), 1);
    chk({tag, ".seq_hold"}, 64'(dut_if.seq_num_o), 64'(m_val));
    repeat (2) tick();
    chk({tag, ".one_done"}, 64'(done_cnt - dc0), 1);
  endtask

  task automatic run_field(input string tag, input logic [31:0] exp_seq,
                           input bit end_with_last, input bit gaps);
    model(exp_seq);
    drive_field(exp_seq, end_with_last, gaps);
    finish_field(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ready"},   64'(dut_if.ready_o), 1);
    chk({tag, ".done"},    64'(dut_if.done_o), 0);
    chk({tag, ".seq"},     64'(dut_if.seq_num_o), 0);
    chk({tag, ".width"},   64'(dut_if.width_o), 0);
    chk({tag, ".status"},  64'({dut_if.in_sequence_o, dut_if.gap_o,
                                dut_if.too_low_o, dut_if.error_o}), 0);
    chk({tag, ".gap_sz"},  64'(dut_if.gap_size_o), 0);
  endtask

  initial begin
    int dc0;
    int len, r;
    logic [31:0] exp_seq;
    byte unsigned b;

    rst = 1;
    clear_in();
    dut_if.expected_seq_num_i = 0;
    repeat (3) tick();
    rst = 0;
    tick();
    check_reset_vals("reset");

    set_fld("1234");
    run_field("inseq_1234", 32'd1234, 0, 0);
    chk("inseq_1234.hex", 64'(dut_if.seq_num_o), 64'h4D2);
    set_fld("130");
    run_field("gap_130", 32'd123, 1, 0);
    set_fld("99");
    run_field("low_99", 32'd123, 0, 1);
    set_fld("4294967296");
    run_field("ovf", 32'd5, 0, 0);
    set_fld("4294967295");
    run_field("max", 32'hFFFF_FFFF, 1, 0);
    chk("max.hex", 64'(dut_if.seq_num_o), 64'hFFFF_FFFF);
    set_fld("12A4");
    run_field("nondigit", 32'd12, 0, 0);
    set_fld("11111111111");
    run_field("eleven", 32'd1, 0, 0);
    set_fld(" ");
    run_field("no_digits", 32'd0, 0, 0);
    set_fld("0000000007");
    run_field("lead_zero", 32'd7, 1, 1);

    // Restart: "12" abandoned by a new start carrying "7" with field_end.
    set_fld("7");
    model(32'd7);
    dut_if.expected_seq_num_i = 32'd7;
    dut_if.byte_valid_i = 1; dut_if.field_start_i = 1; dut_if.byte_i = "1";
    tick();
    dut_if.field_start_i = 0; dut_if.byte_i = "2";
    tick();
    dut_if.field_start_i = 1; dut_if.field_end_i = 1; dut_if.byte_i = "7";
    tick();
    clear_in();
    finish_field("restart");

    // Reset mid-field aborts with no result.
    dc0 = done_cnt;
    dut_if.byte_valid_i = 1; dut_if.field_start_i = 1; dut_if.byte_i = "5";
    tick();
    dut_if.field_start_i = 0; dut_if.byte_i = "6";
    tick();
    clear_in();
    rst = 1;
    tick();
    rst = 0;
    repeat (4) tick();
    chk("midrst.no_done", 64'(done_cnt - dc0), 0);
    check_reset_vals("midrst");
    set_fld("3");
    run_field("after_rst", 32'd3, 1, 0);

    for (int n = 0; n < 300; n++) begin
      fld.delete();
      len = $urandom_range(1, 12);
      r   = $urandom_range(0, 3);
      if (r == 0) len = 10;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 99) < 3) begin
          b = 8'($urandom_range(0, 255));
          if (b >= 8'h30 && b <= 8'h39) b = 8'h3A;
        end else if (r == 0 && i == 0) begin
          b = 8'h34;
        end else begin
          b = 8'(8'h30 + $urandom_range(0, 9));
        end
        fld.push_back(b);
      end
      model(0);
      if ($urandom_range(0, 2) != 0) exp_seq = m_raw[31:0] + 32'($urandom_range(0, 4)) - 32'd2;
      else exp_seq = $urandom;
      run_field("rand", exp_seq, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
